// File: rtl/proc_pkg.sv
// Shared constants and fetch-state encoding for the 16-bit processor front end.
package proc_pkg;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Boot stream, IM port and control-unit signals seen by the fetch sequencer.
interface fetch_sequencer_if;
  import proc_pkg::*;

  logic               boot_valid;
  logic [INSTR_W-1:0] boot_data;
  logic               boot_last;
  logic               boot_ready;
  logic               boot_overflow;
  logic               im_en_write;
  logic [ADDR_W-1:0]  im_address;
  logic [INSTR_W-1:0] im_data_in;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               halt;
  logic               instr_valid;
  logic [ADDR_W-1:0]  instr_pc;
  logic [ADDR_W-1:0]  pc;
  logic               running;

  modport seq (
    input  boot_valid, boot_data, boot_last, stall, branch_taken, branch_target, halt,
    output boot_ready, boot_overflow, im_en_write, im_address, im_data_in,
           instr_valid, instr_pc, pc, running
  );

  modport env (
    output boot_valid, boot_data, boot_last, stall, branch_taken, branch_target, halt,
    input  boot_ready, boot_overflow, im_en_write, im_address, im_data_in,
           instr_valid, instr_pc, pc, running
  );
endinterface

// File: rtl/pc_counter.sv
// Address register with load, hold and wrapping increment; used for load_ptr and pc.
module pc_counter
  import proc_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // Load wins over increment; the increment wraps naturally at 2^W.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_q <= '0;
    else if (i_load) r_q <= i_load_val;
    else if (i_inc)  r_q <= r_q + 1'b1;
  end

  assign o_q = r_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Boot-loads IM from a word stream, then sequences the PC with halt/branch/stall control.
module fetch_sequencer
  import proc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fetch_sequencer_if.seq bus
);
  fetch_state_e      r_state, w_state_nxt;
  logic              r_overflow;
  logic              r_instr_valid;
  logic [ADDR_W-1:0] r_instr_pc;

  logic              w_boot_ready;
  logic              w_accept;
  logic              w_pc_load;
  logic [ADDR_W-1:0] w_pc_load_val;
  logic              w_pc_inc;
  logic              w_issue;
  logic [ADDR_W-1:0] w_im_address;
  logic [ADDR_W-1:0] w_load_ptr;
  logic [ADDR_W-1:0] w_pc;

  pc_counter #(.W(ADDR_W)) u_load_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_accept),
    .o_q        (w_load_ptr)
  );

  pc_counter #(.W(ADDR_W)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_pc_load),
    .i_load_val (w_pc_load_val),
    .i_inc      (w_pc_inc),
    .o_q        (w_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_boot_ready  = 1'b0;
    w_accept      = 1'b0;
    w_pc_load     = 1'b0;
    w_pc_load_val = '0;
    w_pc_inc      = 1'b0;
    w_issue       = 1'b0;
    w_im_address  = w_pc;
    case (r_state)
      BOOT: begin
        // Held low while reset is asserted so no IM write slips through.
        w_boot_ready = rst_n;
        w_accept     = bus.boot_valid & w_boot_ready;
        w_im_address = w_load_ptr;
        if (w_accept && bus.boot_last) begin
          w_state_nxt = RUN;
          w_pc_load   = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt) begin
          w_state_nxt = HALTED;
        end else if (bus.branch_taken) begin
          w_pc_load     = 1'b1;
          w_pc_load_val = bus.branch_target;
        end else if (!bus.stall) begin
          w_pc_inc = 1'b1;
          w_issue  = 1'b1;
        end
      end
      HALTED: ;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Overflow marks a pointer wrap that happens before the final boot word.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_overflow <= 1'b0;
    else if (w_accept && (&w_load_ptr) && !bus.boot_last)
      r_overflow <= 1'b1;
  end

  // IM read data arrives one cycle after the address; valid/pc follow it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_valid <= 1'b0;
      r_instr_pc    <= '0;
    end else begin
      r_instr_valid <= w_issue;
      if (w_issue) r_instr_pc <= w_pc;
    end
  end

  assign bus.boot_ready    = w_boot_ready;
  assign bus.boot_overflow = r_overflow;
  assign bus.im_en_write   = w_accept;
  assign bus.im_address    = w_im_address;
  assign bus.im_data_in    = bus.boot_data;
  assign bus.instr_valid   = r_instr_valid;
  assign bus.instr_pc      = r_instr_pc;
  assign bus.pc            = w_pc;
  assign bus.running       = (r_state == RUN);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural 1-cycle-latency IM.
module tb_fetch_sequencer;
  import proc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [INSTR_W-1:0] mem [1024];
  logic [INSTR_W-1:0] im_dout;

  always @(posedge clk) begin
    if (bus.im_en_write) mem[bus.im_address] <= bus.im_data_in;
    im_dout <= mem[bus.im_address];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [INSTR_W-1:0] prog [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    prog[0] = 16'h040D; prog[1] = 16'h280C; prog[2] = 16'h2C14; prog[3] = 16'h080D;
    rst_n = 1'b0;
    bus.boot_valid = 1'b0; bus.boot_data = '0; bus.boot_last = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0; bus.halt = 1'b0;
    tick(); tick();
    chk("rst_pc",    32'(bus.pc), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_ipc",   32'(bus.instr_pc), 0);
    chk("rst_we",    32'(bus.im_en_write), 0);
    chk("rst_addr",  32'(bus.im_address), 0);
    chk("rst_ready", 32'(bus.boot_ready), 0);
    chk("rst_run",   32'(bus.running), 0);
    chk("rst_ovf",   32'(bus.boot_overflow), 0);

    // Boot four words
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.boot_valid = 1'b1; bus.boot_data = prog[i]; bus.boot_last = (i == 3);
      #1;
      chk("boot_ready", 32'(bus.boot_ready), 1);
      chk("boot_we",    32'(bus.im_en_write), 1);
      chk("boot_addr",  32'(bus.im_address), 32'(i));
      tick();
    end
    bus.boot_valid = 1'b0; bus.boot_last = 1'b0;
    #1;
    chk("run_first",  32'(bus.running), 1);
    chk("run_addr0",  32'(bus.im_address), 0);
    chk("run_valid0", 32'(bus.instr_valid), 0);
    chk("run_we0",    32'(bus.im_en_write), 0);
    chk("run_ready0", 32'(bus.boot_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("seq_valid", 32'(bus.instr_valid), 1);
      chk("seq_ipc",   32'(bus.instr_pc), 32'(k));
      chk("seq_data",  32'(im_dout), 32'(prog[k]));
      chk("seq_pc",    32'(bus.pc), 32'(k + 1));
    end

    // Branch to 2 while pc=3
    bus.branch_taken = 1'b1; bus.branch_target = 10'h002;
    tick();
    bus.branch_taken = 1'b0;
    chk("br_addr",   32'(bus.im_address), 2);
    chk("br_valid",  32'(bus.instr_valid), 0);
    tick();
    chk("br_valid2", 32'(bus.instr_valid), 1);
    chk("br_ipc",    32'(bus.instr_pc), 2);
    chk("br_data",   32'(im_dout), 32'(prog[2]));

    // Redirect to 1 then stall 3 cycles
    bus.branch_taken = 1'b1; bus.branch_target = 10'h001;
    tick();
    bus.branch_taken = 1'b0;
    chk("br1_pc", 32'(bus.pc), 1);
    bus.stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_pc",    32'(bus.pc), 1);
      chk("stall_valid", 32'(bus.instr_valid), 0);
    end
    bus.stall = 1'b0;
    tick();
    chk("unstall_valid", 32'(bus.instr_valid), 1);
    chk("unstall_ipc",   32'(bus.instr_pc), 1);
    chk("unstall_data",  32'(im_dout), 32'(prog[1]));
    chk("unstall_pc",    32'(bus.pc), 2);

    // Halt wins over a simultaneous branch
    bus.halt = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 10'h005;
    tick();
    bus.halt = 1'b0; bus.branch_taken = 1'b0;
    chk("halt_run",   32'(bus.running), 0);
    chk("halt_pc",    32'(bus.pc), 2);
    chk("halt_valid", 32'(bus.instr_valid), 0);
    repeat (10) begin
      tick();
      chk("halted_valid", 32'(bus.instr_valid), 0);
      chk("halted_pc",    32'(bus.pc), 2);
      chk("halted_we",    32'(bus.im_en_write), 0);
    end

    // 1025 words without boot_last
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i <= 1024; i++) begin
      bus.boot_valid = 1'b1; bus.boot_data = 16'(i) ^ 16'h5A5A; bus.boot_last = 1'b0;
      #1;
      if (i == 0 || i == 1023 || i == 1024) begin
        chk("ovf_addr", 32'(bus.im_address), 32'(i % 1024));
        chk("ovf_we",   32'(bus.im_en_write), 1);
      end
      tick();
      if (i == 1022) chk("ovf_before", 32'(bus.boot_overflow), 0);
      if (i == 1023) chk("ovf_after",  32'(bus.boot_overflow), 1);
    end
    bus.boot_valid = 1'b0;
    chk("ovf_mem0",  32'(mem[0]), 32'(16'h0400 ^ 16'h5A5A));
    chk("ovf_mem1",  32'(mem[1]), 32'(16'h0001 ^ 16'h5A5A));
    chk("ovf_run",   32'(bus.running), 0);
    chk("ovf_stick", 32'(bus.boot_overflow), 1);

    // Two more words, then reset mid-boot
    for (int i = 0; i < 2; i++) begin
      bus.boot_valid = 1'b1; bus.boot_data = 16'hBEE0 + 16'(i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_ready_lo", 32'(bus.boot_ready), 0);
    chk("mid_we_lo",    32'(bus.im_en_write), 0);
    tick();
    chk("mid_pc",    32'(bus.pc), 0);
    chk("mid_addr",  32'(bus.im_address), 0);
    chk("mid_ovf",   32'(bus.boot_overflow), 0);
    chk("mid_valid", 32'(bus.instr_valid), 0);
    chk("mid_ipc",   32'(bus.instr_pc), 0);
    chk("mid_run",   32'(bus.running), 0);
    chk("mid_we",    32'(bus.im_en_write), 0);
    rst_n = 1'b1;
    bus.boot_data = 16'h1234; bus.boot_last = 1'b1;
    #1;
    chk("reboot_addr", 32'(bus.im_address), 0);
    chk("reboot_we",   32'(bus.im_en_write), 1);
    tick();
    bus.boot_valid = 1'b0; bus.boot_last = 1'b0;
    chk("reboot_run",  32'(bus.running), 1);
    chk("reboot_mem",  32'(mem[0]), 32'h1234);
    tick();
    chk("reboot_valid", 32'(bus.instr_valid), 1);
    chk("reboot_ipc",   32'(bus.instr_pc), 0);
    chk("reboot_data",  32'(im_dout), 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
